// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a circular FIFO feeds an 8N1-style serializer
// (start bit, NUM_DATA_BITS data bits LSB first, one stop bit).
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT  = 217,
    parameter int NUM_DATA_BITS = 8,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_wrStrobe,
    input  logic [NUM_DATA_BITS-1:0]      i_wrByte,
    output logic                          o_tx,
    output logic                          o_txActive,
    output logic                          o_txDoneStrobe,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_overflowFlag
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(NUM_DATA_BITS);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(NUM_DATA_BITS - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // ---------------- FIFO ----------------
    logic [NUM_DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_reg;
    logic [PTR_W-1:0]         rd_ptr_reg;
    logic [CNT_W-1:0]         count_reg;
    logic                     overflow_reg;
    logic                     full;
    logic                     empty;
    logic                     wr_accept;
    logic                     pop;

    assign full      = (count_reg == CNT_FULL);
    assign empty     = (count_reg == '0);
    assign wr_accept = i_wrStrobe & ~full;

    // Storage carries no reset so it maps onto plain RAM.
    always_ff @(posedge i_clk) begin
        if (wr_accept) begin
            mem[wr_ptr_reg] <= i_wrByte;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({wr_accept, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
            // A write against a full FIFO is lost even if a pop frees a slot this cycle.
            if (i_wrStrobe && full) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // ---------------- Serializer ----------------
    state_t                   state_reg, state_next;
    logic [BAUD_W-1:0]        baud_reg, baud_next;
    logic [BIT_W-1:0]         bit_idx_reg, bit_idx_next;
    logic [NUM_DATA_BITS-1:0] shift_reg, shift_next;
    logic                     tx_reg, tx_next;
    logic                     active_reg, active_next;
    logic                     done_reg, done_next;
    logic                     baud_end;

    assign baud_end = (baud_reg == BAUD_LAST);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg   <= IDLE;
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
            active_reg  <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            baud_reg    <= baud_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            tx_reg      <= tx_next;
            active_reg  <= active_next;
            done_reg    <= done_next;
        end
    end

    // Line outputs are the registered image of the current state, so o_tx
    // trails the state register by exactly one cycle for every bit.
    always_comb begin
        state_next   = state_reg;
        baud_next    = baud_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        pop          = 1'b0;
        tx_next      = 1'b1;
        done_next    = 1'b0;
        active_next  = (state_reg != IDLE);

        case (state_reg)
            IDLE: begin
                tx_next = 1'b1;
                if (!empty) begin
                    pop          = 1'b1;
                    shift_next   = mem[rd_ptr_reg];
                    baud_next    = '0;
                    bit_idx_next = '0;
                    state_next   = START;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (baud_end) begin
                    baud_next    = '0;
                    bit_idx_next = '0;
                    state_next   = DATA;
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
            DATA: begin
                tx_next = shift_reg[0];
                if (baud_end) begin
                    baud_next  = '0;
                    shift_next = shift_reg >> 1;
                    if (bit_idx_reg == BIT_LAST) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + BIT_W'(1);
                    end
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
            STOP: begin
                tx_next = 1'b1;
                if (baud_end) begin
                    baud_next = '0;
                    done_next = 1'b1;
                    // Chain straight into the next frame to avoid an idle gap.
                    if (!empty) begin
                        pop          = 1'b1;
                        shift_next   = mem[rd_ptr_reg];
                        bit_idx_next = '0;
                        state_next   = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign o_tx           = tx_reg;
    assign o_txActive     = active_reg;
    assign o_txDoneStrobe = done_reg;
    assign o_full         = full;
    assign o_empty        = empty;
    assign o_count        = count_reg;
    assign o_overflowFlag = overflow_reg;

endmodule
